relm_div_seq: RTL
=================

# relm_div_seq

Self-sequencing multi-bit integer divider for the ReLM custom-operation path. It replaces the software-driven divide step loop, where each custom opcode retires a few quotient bits, with a block that takes one start pulse and runs to completion. It computes QB quotient bits per clock using 1·D/2·D/3·D style multiple comparison, supports signed and unsigned operands, and holds quotient and remainder until the next start. It sits beside the combinational custom unit and is polled via `busy_out` / `done_out`.

## Interface
- `WD`, 32: operand/result width; must be a multiple of `QB`.
- `QB`, 2: quotient bits retired per cycle; legal values 1, 2, 4. Divisor multiples 1·D … (2^QB−1)·D are precomputed at start.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_in`  in  1  request; sampled only in IDLE or DONE.
- `signed_in`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start_in`.
- `n_in`  in  WD  dividend; sampled with `start_in`.
- `d_in`  in  WD  divisor; sampled with `start_in`.
- `busy_out`  out  1  high while iterating (RUN and FIX).
- `done_out`  out  1  one-cycle pulse when results become valid.
- `q_out`  out  WD  quotient; held until the next accepted start.
- `r_out`  out  WD  remainder; held until the next accepted start.
- `dz_out`  out  1  divide-by-zero flag for the held result.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + `start_in`:
  - latch |n|, |d| (abs only when `signed_in`), `q_neg` = sn^sd, `r_neg` = sn.
  - precompute multiples of |d| at WD+QB bits; clear partial remainder; load iteration counter with WD/QB−1.
  - → RUN, or → DONE directly if `d_in`==0.
- RUN, each cycle:
  - shift QB dividend bits into the partial remainder R.
  - select the largest k in 0..2^QB−1 with k·|d| ≤ R; R −= k·|d|; shift k into the quotient.
  - counter decrements; leave to FIX when the counter is 0.
- FIX: q_out = q_neg ? −Q : Q; r_out = r_neg ? −R : R (WD-bit wrap); → DONE.
- DONE: `done_out`=1 for exactly this cycle; → IDLE unless a new start is accepted (→ RUN/DONE as from IDLE).
- Divide by zero: q_out = all ones, r_out = n_in unmodified (signed or not), dz_out = 1. Any other result clears dz_out.
- Signed overflow (−2^(WD−1) / −1): q_out = −2^(WD−1), r_out = 0. This falls out of the abs/negate path; no special case.
- Remainder sign always follows the dividend; |r| < |d|.
- `start_in` in RUN or FIX is ignored; no queuing.
- `reset` in any state: → IDLE next edge, in-flight operation discarded, no `done_out`.

## Timing
- Reset values: state IDLE; busy_out 0, done_out 0, q_out 0, r_out 0, dz_out 0.
- Start accepted on edge E0. Then RUN for WD/QB edges, then FIX for 1 edge.
- `done_out` is high in the cycle after edge E0+WD/QB+1, giving latency L = WD/QB+2 cycles from the start cycle. Example: WD=32, QB=2 → done visible 18 cycles after the start cycle.
- Divide-by-zero: `done_out` is high in the cycle immediately after E0 (latency 1).
- `busy_out` is high from the cycle after E0 through the FIX cycle inclusive, and low in DONE.
- `q_out`/`r_out`/`dz_out` update only on the FIX edge (or the E0 edge for divide-by-zero); they are stable in DONE and afterwards.
- Back-to-back: a start asserted in the DONE cycle is accepted, so the throughput is one divide per L cycles.
- Critical path: the compare against 2^QB−1 multiples plus the subtract; no multi-cycle paths.

## Test plan
- Unsigned: 100 / 7, WD=32, QB=2 → q=14, r=2, dz=0; done at start+18; busy high exactly 17 cycles.
- Signed: −100 / 7 → q=0xFFFFFFF2, r=0xFFFFFFFE. Then 100 / −7 → q=0xFFFFFFF2, r=2.
- Divide by zero: 5 / 0 (signed and unsigned) → q=0xFFFFFFFF, r=5, dz=1; done one cycle after start; a following 9 / 3 clears dz and gives q=3, r=0.
- Extremes:
  - signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0.
  - unsigned 0xFFFFFFFF / 1 → q=0xFFFFFFFF, r=0.
  - unsigned 0xFFFFFFFF / 0xFFFFFFFF → q=1, r=0.
- Control:
  - start pulsed mid-RUN is ignored; results match the first operands.
  - reset asserted at RUN cycle 5 → busy 0 and outputs 0 next cycle, no done pulse.
  - start asserted in the DONE cycle → second result arrives L cycles later.
- Sweep: QB ∈ {1,2,4}, WD ∈ {16,32}, 10k random signed/unsigned pairs against a reference model; latency equals WD/QB+2 for every pair.

Source files
------------

// File: rtl/relm_div_seq_if.sv
// -----------------------------------------------------------------------------
// relm_div_seq_if
//
// Request/response bundle between a requester (ReLM custom-operation path) and
// the self-sequencing divider relm_div_seq.
//
// Signals:
//   start_in   requester -> divider  start request, sampled in IDLE/DONE
//   signed_in  requester -> divider  1 = two's-complement operands
//   n_in       requester -> divider  dividend (WD bits)
//   d_in       requester -> divider  divisor  (WD bits)
//   busy_out   divider -> requester  high while iterating (RUN and FIX)
//   done_out   divider -> requester  one-cycle pulse when results become valid
//   q_out      divider -> requester  quotient, held until the next start
//   r_out      divider -> requester  remainder, held until the next start
//   dz_out     divider -> requester  divide-by-zero flag for the held result
//
// Modports: master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface relm_div_seq_if #(
    parameter int WD = 32
);
    logic          start_in;
    logic          signed_in;
    logic [WD-1:0] n_in;
    logic [WD-1:0] d_in;
    logic          busy_out;
    logic          done_out;
    logic [WD-1:0] q_out;
    logic [WD-1:0] r_out;
    logic          dz_out;

    modport master (
        output start_in, signed_in, n_in, d_in,
        input  busy_out, done_out, q_out, r_out, dz_out
    );

    modport slave (
        input  start_in, signed_in, n_in, d_in,
        output busy_out, done_out, q_out, r_out, dz_out
    );
endinterface

// File: rtl/relm_div_seq.sv
// -----------------------------------------------------------------------------
// relm_div_seq
//
// Self-sequencing integer divider. One accepted start runs the whole divide:
// QB quotient bits are retired per clock by comparing the shifted partial
// remainder against the precomputed multiples 1*|d| .. (2^QB-1)*|d| and
// subtracting the largest one that fits. Signed operands are divided as
// magnitudes and the signs are restored in a final FIX cycle. Results are
// held until the next accepted start.
//
// Parameters:
//   WD  operand/result width, a multiple of QB
//   QB  quotient bits per cycle (1, 2 or 4)
//
// Ports:
//   clk    single clock, all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    relm_div_seq_if.slave (start/operands in, busy/done/results out)
//
// Latency: WD/QB+2 cycles from the start cycle to done_out; 1 cycle for a
// zero divisor. A start in the DONE cycle is accepted (back-to-back).
// -----------------------------------------------------------------------------
module relm_div_seq #(
    parameter int WD = 32,
    parameter int QB = 2
) (
    input  logic          clk,
    input  logic          reset,
    relm_div_seq_if.slave bus
);
    localparam int ITER = WD / QB;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int KMAX = (1 << QB) - 1;
    localparam int XW   = WD + QB;   // room for the partial remainder after a QB-bit shift

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    // Control and registered outputs.
    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic          dz_q;
    logic [WD-1:0] q_q;
    logic [WD-1:0] r_q;

    // Datapath. nq_q holds the dividend magnitude; its top QB bits feed the
    // partial remainder each step while quotient digits enter at the bottom,
    // so after ITER steps it holds the unsigned quotient.
    logic [WD-1:0] nq_q;
    logic [WD-1:0] rem_q;
    logic [CW-1:0] cnt_q;
    logic          q_neg_q;
    logic          r_neg_q;
    logic [XW-1:0] mult_q [1:KMAX];

    // Start decode.
    logic          accept;
    logic          d_zero;
    logic          n_sign;
    logic          d_sign;
    logic [WD-1:0] abs_n;
    logic [WD-1:0] abs_d;
    logic [XW-1:0] mult_d [1:KMAX];

    // One iteration step and the sign fix-up.
    logic [XW-1:0] rem_sh;
    logic [QB-1:0] k_sel;
    logic [WD-1:0] rem_d;
    logic [WD-1:0] nq_d;
    logic [WD-1:0] q_fix;
    logic [WD-1:0] r_fix;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        accept = bus.start_in && ((state_q == S_IDLE) || (state_q == S_DONE));
        d_zero = (bus.d_in == '0);
        n_sign = bus.signed_in & bus.n_in[WD-1];
        d_sign = bus.signed_in & bus.d_in[WD-1];
        abs_n  = n_sign ? -bus.n_in : bus.n_in;
        abs_d  = d_sign ? -bus.d_in : bus.d_in;

        for (int k = 1; k <= KMAX; k++) begin
            mult_d[k] = '0;
        end
        // Successive additions build k*|d|; at XW bits none of them wrap, so
        // the multiples are strictly increasing.
        mult_d[1] = XW'(abs_d);
        for (int k = 2; k <= KMAX; k++) begin
            mult_d[k] = mult_d[k-1] + XW'(abs_d);
        end
    end

    always_comb begin
        rem_sh = {rem_q, nq_q[WD-1 -: QB]};
        k_sel  = '0;
        rem_d  = rem_q;
        // Multiples are increasing, so the last one that fits is the largest.
        // A k of 0 means nothing fits and the shifted remainder passes through.
        rem_d  = WD'(rem_sh);
        for (int k = 1; k <= KMAX; k++) begin
            if (mult_q[k] <= rem_sh) begin
                k_sel = QB'(k);
                rem_d = WD'(rem_sh - mult_q[k]);
            end
        end
        nq_d  = (nq_q << QB) | WD'(k_sel);

        // Magnitudes are restored to signed form with WD-bit wrap; the
        // -2^(WD-1) / -1 case wraps back to -2^(WD-1) on its own.
        q_fix = q_neg_q ? -nq_q : nq_q;
        r_fix = r_neg_q ? -rem_q : rem_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (d_zero) begin
                            // Divide by zero completes at once with fixed results.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                            q_q     <= '1;
                            r_q     <= bus.n_in;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    dz_q    <= 1'b0;
                    q_q     <= q_fix;
                    r_q     <= r_fix;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: the datapath registers (including the multiple table) carry no
    // reset: each is loaded on an accepted start before it is ever read, and
    // parking the FSM in IDLE is enough to discard an in-flight divide.
    always_ff @(posedge clk) begin
        if (accept) begin
            nq_q    <= abs_n;
            rem_q   <= '0;
            cnt_q   <= CW'(ITER - 1);
            q_neg_q <= n_sign ^ d_sign;
            r_neg_q <= n_sign;
            mult_q  <= mult_d;
        end else if (state_q == S_RUN) begin
            nq_q  <= nq_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign bus.busy_out = busy_q;
    assign bus.done_out = done_q;
    assign bus.q_out    = q_q;
    assign bus.r_out    = r_q;
    assign bus.dz_out   = dz_q;

endmodule
